dev_alu_seq: RTL and testbench

Parametrised successor of the single-cycle accumulator ALU. It adds OR/XOR/SAR, a full-width unsigned multiplier and a divider. All operand widths are generic. Results and flags are held in registers, and a valid/ready/done handshake covers the multi-cycle operations. It sits in the CPU datapath between the register-file read ports and the writeback/flags logic, and the control FSM stalls on ready.

---
 rtl/dev_alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_dev_alu_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dev_alu_seq.sv
// dev_alu_seq: registered accumulator-style ALU with multi-cycle MULU/DIVU/REMU.
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   op, a, b        : opcode and operands; result = b op a (a is the shift amount)
//   valid, ready    : request handshake; a request is accepted on an edge with valid && ready
//   done            : one-cycle pulse after s/flags were updated
//   s, cf/of/zf/sf  : registered result and flags
// Single-cycle ops (ADD..SAR) latch at the accept edge. MULU runs a shift-add and
// DIVU/REMU a restoring divide, each one step per edge for WIDTH edges.
module dev_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             sf
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SAR  = 4'd8;
    localparam logic [3:0] OP_MULU = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    state_e               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    // MUL: {partial high, multiplier shifting out low}. DIV: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor
    logic                 rem_sel_q, rem_sel_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 cf_q, cf_d, of_q, of_d, done_q, done_d;

    // Single-cycle ALU
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_of;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;

    assign shamt = a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        sum     = '0;
        unique case (op)
            OP_ADD: begin
                sum     = {1'b0, b} + {1'b0, a};
                alu_res = sum[MSB:0];
                alu_cf  = sum[WIDTH];
                alu_of  = (b[MSB] == a[MSB]) && (sum[MSB] != b[MSB]);
            end
            OP_SUB: begin
                sum     = {1'b0, b} - {1'b0, a};
                alu_res = sum[MSB:0];
                alu_cf  = sum[WIDTH];   // borrow
                alu_of  = (b[MSB] != a[MSB]) && (sum[MSB] != b[MSB]);
            end
            OP_AND:  alu_res = b & a;
            OP_OR:   alu_res = b | a;
            OP_XOR:  alu_res = b ^ a;
            OP_SHL:  alu_res = b << shamt;
            OP_SHR:  alu_res = b >> shamt;
            OP_SAR:  alu_res = $signed(b) >>> shamt;
            default: ;
        endcase
    end

    // One shift-add multiply step: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole product right.
    logic [WIDTH:0]       mul_add;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_add, prod_q[MSB:1]};

    // One restoring divide step. With a zero divisor every trial succeeds, which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    logic [WIDTH:0]       div_trial, div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    assign div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[MSB]};
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_rem   = div_ge ? (div_trial - {1'b0, opnd_q}) : div_trial;
    assign div_next  = {div_rem[MSB:0], prod_q[MSB-1:0], div_ge};

    logic last_step;
    assign last_step = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        rem_sel_d = rem_sel_q;
        s_d       = s_q;
        cf_d      = cf_q;
        of_d      = of_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: if (valid) begin
                unique case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SAR: begin
                        s_d    = alu_res;
                        cf_d   = alu_cf;
                        of_d   = alu_of;
                        done_d = 1'b1;
                    end
                    OP_MULU: begin
                        prod_d  = {{WIDTH{1'b0}}, a};
                        opnd_d  = b;
                        cnt_d   = '0;
                        state_d = MUL;
                    end
                    OP_DIVU, OP_REMU: begin
                        prod_d    = {{WIDTH{1'b0}}, b};
                        opnd_d    = a;
                        rem_sel_d = (op == OP_REMU);
                        cnt_d     = '0;
                        state_d   = DIV;
                    end
                    default: ;   // NOP / reserved: accepted, nothing changes
                endcase
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_step) begin
                    s_d     = mul_next[MSB:0];
                    cf_d    = |mul_next[2*WIDTH-1:WIDTH];
                    of_d    = |mul_next[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_step) begin
                    s_d     = rem_sel_q ? div_next[2*WIDTH-1:WIDTH] : div_next[MSB:0];
                    cf_d    = (opnd_q == '0);
                    of_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            rem_sel_q <= 1'b0;
            s_q       <= '0;
            cf_q      <= 1'b0;
            of_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            rem_sel_q <= rem_sel_d;
            s_q       <= s_d;
            cf_q      <= cf_d;
            of_q      <= of_d;
            done_q    <= done_d;
        end
    end

    // zf/sf are decoded from the result register, so they always track s.
    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign s     = s_q;
    assign cf    = cf_q;
    assign of    = of_q;
    assign zf    = (s_q == '0);
    assign sf    = s_q[MSB];
endmodule

// File: tb/tb_dev_alu_seq.sv
module tb_dev_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         valid;
    logic         ready, done;
    logic [W-1:0] s;
    logic         cf, of, zf, sf;
    logic [3:0]   fl;

    int checks = 0;
    int errors = 0;

    dev_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .valid(valid),
        .ready(ready), .done(done), .s(s), .cf(cf), .of(of), .zf(zf), .sf(sf)
    );

    always #5 clk = ~clk;
    assign fl = {cf, of, zf, sf};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] bb, input logic [W-1:0] aa);
        @(negedge clk);
        op = o; b = bb; a = aa; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Multi-cycle op: expects 16 busy cycles and done in the 17th cycle after accept.
    task automatic run_mc(input string tag, input logic [3:0] o, input logic [W-1:0] bb,
                          input logic [W-1:0] aa, input bit poke);
        int cyc, lows;
        issue(o, bb, aa);
        cyc = 1; lows = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (ready === 1'b0) lows++;
            if (poke && cyc == 5) begin op = 4'd1; a = 16'h1111; b = 16'h2222; valid = 1'b1; end
            if (poke && cyc == 6) valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 17);
        chk({tag, "_busy"}, lows, 16);
        chk({tag, "_rdy"}, ready, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_fl", fl, 4'b0010);
        chk("rst_rdy", ready, 1);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Reset in the middle of a divide
        issue(4'd1, 16'd1, 16'd2);
        chk("pre_s", s, 3);
        issue(4'd10, 16'd100, 16'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s", s, 0);
        chk("mid_rst_fl", fl, 4'b0010);
        chk("mid_rst_rdy", ready, 1);
        @(negedge clk);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        issue(4'd1, 16'd1, 16'd2);
        chk("post_rst_s", s, 3);
        chk("post_rst_done", done, 1);

        // Back-to-back ADD/SUB with flags
        @(negedge clk);
        op = 4'd1; b = 16'h7FFF; a = 16'h0001; valid = 1'b1;
        @(negedge clk);
        chk("b2b1_done", done, 1); chk("add_ovf_s", s, 16'h8000); chk("add_ovf_fl", fl, 4'b0101);
        op = 4'd2; b = 16'h0000; a = 16'h0001;
        @(negedge clk);
        chk("b2b2_done", done, 1); chk("sub_brw_s", s, 16'hFFFF); chk("sub_brw_fl", fl, 4'b1001);
        op = 4'd1; b = 16'hFFFF; a = 16'h0001;
        @(negedge clk);
        chk("b2b3_done", done, 1); chk("add_cy_s", s, 16'h0000); chk("add_cy_fl", fl, 4'b1010);
        valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_done", done, 0);

        // Logic ops clear carry left by a borrow
        issue(4'd2, 16'h0000, 16'h0001);
        issue(4'd3, 16'hF0F0, 16'hFF00);
        chk("and_s", s, 16'hF000); chk("and_fl", fl, 4'b0001);
        issue(4'd4, 16'hF0F0, 16'hFF00);
        chk("or_s", s, 16'hFFF0);
        issue(4'd5, 16'hF0F0, 16'hFF00);
        chk("xor_s", s, 16'h0FF0); chk("xor_fl", fl, 4'b0000);

        // Shifts (upper bits of the amount ignored)
        issue(4'd8, 16'h8000, 16'h0013);
        chk("sar_s", s, 16'hF000); chk("sar_fl", fl, 4'b0001);
        issue(4'd7, 16'h8000, 16'h0013);
        chk("shr_s", s, 16'h1000); chk("shr_fl", fl, 4'b0000);
        issue(4'd6, 16'h0001, 16'd15);
        chk("shl_s", s, 16'h8000); chk("shl_fl", fl, 4'b0001);

        // Multiply
        run_mc("mul_hi", 4'd9, 16'h0100, 16'h0100, 1'b1);
        chk("mul_hi_s", s, 16'h0000); chk("mul_hi_fl", fl, 4'b1110);
        run_mc("mul_lo", 4'd9, 16'd300, 16'd200, 1'b0);
        chk("mul_lo_s", s, 16'd60000); chk("mul_lo_fl", fl, 4'b0001);

        // Divide / remainder, including divide by zero
        run_mc("divu", 4'd10, 16'd100, 16'd7, 1'b0);
        chk("divu_s", s, 16'd14); chk("divu_fl", fl, 4'b0000);
        run_mc("remu", 4'd11, 16'd100, 16'd7, 1'b0);
        chk("remu_s", s, 16'd2);
        run_mc("divz", 4'd10, 16'd5, 16'd0, 1'b0);
        chk("divz_s", s, 16'hFFFF); chk("divz_fl", fl, 4'b1001);
        run_mc("remz", 4'd11, 16'd5, 16'd0, 1'b1);
        chk("remz_s", s, 16'd5); chk("remz_fl", fl, 4'b1000);

        // NOP and reserved opcodes leave everything alone
        issue(4'd1, 16'hFFFF, 16'd4);
        chk("nop_pre_s", s, 3); chk("nop_pre_fl", fl, 4'b1000);
        issue(4'd0, 16'h1234, 16'h5678);
        chk("nop_done", done, 0); chk("nop_rdy", ready, 1);
        chk("nop_s", s, 3); chk("nop_fl", fl, 4'b1000);
        issue(4'd13, 16'h1234, 16'h5678);
        chk("rsv_done", done, 0); chk("rsv_rdy", ready, 1);
        chk("rsv_s", s, 3); chk("rsv_fl", fl, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
